// File: rtl/vga_pkg.sv
// Shared definitions for the VGA character-ROM path.
// Holds the ROM geometry, the request-ownership codes carried alongside
// each ROM read, the host-port FSM state encoding and the tag payload type.
package vga_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;

    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_ACK  = 2'd2
    } host_state_e;

    // Ownership tag travelling with each ROM read.
    typedef struct packed {
        logic vld;
        logic own;
    } rom_tag_t;

endpackage

// File: rtl/vga_tag_pipe.sv
// Shift register that carries the ownership tag of each ROM read so that it
// lines up with the matching rom_data beat.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (clears all stages)
//   tag_in     - tag of the read being issued this cycle
//   tag_out    - tag belonging to the rom_data currently presented
module vga_tag_pipe
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rom_tag_t tag_in,
    output rom_tag_t tag_out
);

    rom_tag_t stage [DEPTH];

    // Plain shift; stage 0 is written in the same edge as rom_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vga_rom_arbiter.sv
// Arbiter sharing the single-port character ROM between the display pixel
// fetch (absolute priority, one read per cycle) and a host loader/debug port
// (req/ack handshake, served only on cycles the display leaves idle).
// Ports:
//   clk, rst_n              - ROM clock, asynchronous active-low reset
//   disp_req, disp_addr     - display read request (one address per cycle)
//   disp_valid, disp_data   - display read return, ROM_LAT+2 cycles after req
//   host_req, host_addr     - host level request, held until host_ack
//   host_ack, host_rdata    - one-cycle ack; rdata held until the next ack
//   starve_err              - sticky flag: host waited STARVE_MAX cycles
//   rom_addr, rom_data      - ROM address out, ROM read data in
module vga_rom_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
    parameter int unsigned DATA_W     = vga_pkg::DATA_W,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 1023,
    parameter int unsigned WAIT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              starve_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int unsigned TAG_DEPTH = ROM_LAT + 1;

    host_state_e       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              issue_disp;
    logic              issue_host;
    logic              count_en;
    logic              ret_disp;
    logic              ret_host;
    rom_tag_t          tag_in;
    rom_tag_t          tag_out;

    // Issue decision: display always wins; host only from H_IDLE.
    always_comb begin
        issue_disp = disp_req;
        issue_host = !disp_req && host_req && (state == H_IDLE);
        tag_in     = '0;
        if (issue_disp) begin
            tag_in = '{vld: 1'b1, own: OWN_DISP};
        end else if (issue_host) begin
            tag_in = '{vld: 1'b1, own: OWN_HOST};
        end
    end

    // Host wait counter: counts only cycles lost to the display, saturating.
    always_comb begin
        count_en = (state == H_IDLE) && host_req && disp_req;
        wait_nxt = wait_cnt;
        if (issue_host || !host_req) begin
            wait_nxt = '0;
        end else if (count_en && (wait_cnt != '1)) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    vga_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign ret_disp = tag_out.vld && (tag_out.own == OWN_DISP);
    assign ret_host = tag_out.vld && (tag_out.own == OWN_HOST);

    // Issue register, return stage, host FSM and starvation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            starve_err <= 1'b0;
            state      <= H_IDLE;
            wait_cnt   <= '0;
        end else begin
            disp_valid <= 1'b0;
            host_ack   <= 1'b0;
            wait_cnt   <= wait_nxt;

            // rom_addr holds on idle cycles to keep the ROM address bus quiet.
            if (issue_disp) begin
                rom_addr <= disp_addr;
            end else if (issue_host) begin
                rom_addr <= host_addr;
            end

            if (ret_disp) begin
                disp_valid <= 1'b1;
                disp_data  <= rom_data;
            end
            if (ret_host) begin
                host_ack   <= 1'b1;
                host_rdata <= rom_data;
            end

            // H_ACK never issues, giving the requester a cycle to drop req.
            case (state)
                H_IDLE:  if (issue_host) state <= H_WAIT;
                H_WAIT:  if (ret_host)   state <= H_ACK;
                H_ACK:   state <= H_IDLE;
                default: state <= H_IDLE;
            endcase

            if (32'(wait_nxt) >= STARVE_MAX) begin
                starve_err <= 1'b1;
            end
        end
    end

endmodule
